pr_timer_bridge: RTL and testbench
==================================

# pr_timer_bridge

Device-side responder for the CPU's processor bus (PrAddr/PrBE/PrWD/PrWe out, PrRD/HWInt in). Decodes CPU accesses onto two identical memory-mapped countdown timers (TC0, TC1) and returns read data. Assembles the 6-bit hardware interrupt vector the CPU samples: timer requests plus registered external lines.

## Interface
- TC0_BASE, 32'h0000_7F00, word-aligned base of timer 0 (16-byte window)
- TC1_BASE, 32'h0000_7F10, word-aligned base of timer 1 (16-byte window)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- PrAddr  in  32  CPU byte address
- PrBE  in  4  byte enables for writes (bit i -> PrWD[8i+7:8i])
- PrWD  in  32  CPU write data
- PrWe  in  1  write strobe; one write per asserted cycle
- ExtInt  in  4  external device interrupt lines
- PrRD  out  32  read data for current PrAddr (combinational)
- HWInt  out  6  interrupt vector, bits [7:2]: [2]=TC0 irq, [3]=TC1 irq, [7:4]=ExtInt registered

## Operation
- Decode: hit when PrAddr[31:4]==BASE[31:4]; register select PrAddr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
- CTRL: bit0 En, bits[2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as one-shot), bit3 IM (irq mask, 1=enabled); bits[31:4] read 0, write ignored.
- PRESET: 32-bit R/W. COUNT: 32-bit read-only; writes ignored. Reserved: read 0, writes ignored.
- Writes: when PrWe and hit, enabled bytes of CTRL/PRESET updated at the edge; disabled bytes unchanged.
- PrRD: selected register of the hit timer; 32'h0 on miss or reserved.
- Per-timer FSM: IDLE, LOAD, CNT, INT.
  - IDLE: En=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: En=0 -> IDLE (COUNT holds); else COUNT>1 -> COUNT-1; else COUNT<=0 -> INT.
  - INT, mode 01: -> LOAD next edge (irq lasts exactly one cycle).
  - INT, mode 00: hardware clears En on the entering edge; stays in INT until a CTRL write.
- Any CPU write to a timer's CTRL (any PrBE≠0) forces that timer's state to IDLE at that edge, after CTRL is updated; this overrides every other transition, including expiry in the same cycle (no irq produced).
- PRESET writes during CNT do not alter COUNT; used at next LOAD.
- irq = (state==INT) & IM; combinational from registered state.
- HWInt[7:4] <= ExtInt each edge.
- Counting is unsigned; PRESET 0 or 1 both expire after one CNT cycle; no wrap below 0.

## Timing
- Reset (reset=0 at edge): CTRL, PRESET, COUNT = 0, both FSMs IDLE, HWInt = 6'b0; PrRD then reflects zeros.
- Write latency: register visible on PrRD the cycle after the write edge.
- CTRL write setting En at edge 0: LOAD at edge 1, COUNT=PRESET at edge 2, INT entered at edge 2+max(PRESET,1); irq high the following cycle(s).
- Auto-reload period: max(PRESET,1)+2 cycles between irq pulses.
- One-shot: irq held until CTRL write edge; low the next cycle.
- Reset mid-count: all state returns to reset values at that edge; no irq.
- TC0 and TC1 fully independent; simultaneous events on both handled in same cycle.

## Test plan
- Reset: hold reset=0 two cycles with ExtInt=4'hF -> HWInt=0, PrRD=0 at 32'h7F00/04/08.
- One-shot: PRESET=3, CTRL=0x9 to TC0 at edge 0 -> COUNT 3,2,1,0 at edges 2-5, HWInt[2]=1 from edge 5 onward; CTRL readback En=0; CTRL write 0x8 -> HWInt[2]=0 next cycle.
- Auto-reload: TC1 PRESET=2, CTRL=0xB -> HWInt[3] one-cycle pulses every 4 cycles; IM=0 variant -> HWInt[3] stays 0, COUNT still cycles.
- Byte enables: write 32'hAABBCCDD to PRESET with PrBE=4'b0101 from 0 -> readback 32'h00BB00DD; write to COUNT ignored.
- Collision: CTRL write in the cycle COUNT==1 in CNT -> state IDLE, no irq; PRESET=0 -> expiry one cycle after LOAD.
- Decode: read 32'h7F0C and 32'h7F20 -> PrRD=0; ExtInt=4'b1010 -> HWInt[7:4]=4'b1010 one cycle later.

Source files
------------

// File: rtl/pr_timer_bridge.sv
// pr_timer_bridge: processor-bus responder for two countdown timers (TC0, TC1).
// Decodes CPU accesses, returns combinational read data, and builds the
// hardware interrupt vector from timer requests and registered external lines.
module pr_timer_bridge #(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [3:0]  PrBE,
  input  logic [31:0] PrWD,
  input  logic        PrWe,
  input  logic [3:0]  ExtInt,
  output logic [31:0] PrRD,
  output logic [7:2]  HWInt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q  [2];
  logic [3:0]  ctrl_q   [2];
  logic [31:0] preset_q [2];
  logic [31:0] count_q  [2];
  logic [31:0] rd_data  [2];
  logic [1:0]  hit;
  logic [1:0]  wr_ctrl;
  logic [1:0]  wr_preset;
  logic [1:0]  irq;
  logic [3:0]  ext_q;
  logic [1:0]  sel;
  logic        addr_unused;

  assign sel         = PrAddr[3:2];
  assign addr_unused = ^PrAddr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_tc
    localparam logic [31:0] BASE = (g == 0) ? TC0_BASE : TC1_BASE;

    assign hit[g]       = (PrAddr[31:4] == BASE[31:4]);
    assign wr_ctrl[g]   = PrWe && hit[g] && (sel == 2'd0) && (PrBE != 4'b0000);
    assign wr_preset[g] = PrWe && hit[g] && (sel == 2'd1);
    assign irq[g]       = (state_q[g] == INT) && ctrl_q[g][3];

    // Register read mux for this timer
    always_comb begin
      rd_data[g] = '0;
      case (sel)
        2'd0:    rd_data[g] = {28'd0, ctrl_q[g]};
        2'd1:    rd_data[g] = preset_q[g];
        2'd2:    rd_data[g] = count_q[g];
        default: rd_data[g] = '0;
      endcase
    end

    // Timer FSM, counter and CPU-writable registers
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q[g]  <= IDLE;
        ctrl_q[g]   <= '0;
        preset_q[g] <= '0;
        count_q[g]  <= '0;
      end else begin
        case (state_q[g])
          IDLE: if (ctrl_q[g][0]) state_q[g] <= LOAD;
          LOAD: begin
            count_q[g] <= preset_q[g];
            state_q[g] <= CNT;
          end
          CNT: begin
            if (!ctrl_q[g][0]) begin
              state_q[g] <= IDLE;
            end else if (count_q[g] > 32'd1) begin
              count_q[g] <= count_q[g] - 32'd1;
            end else begin
              count_q[g] <= '0;
              state_q[g] <= INT;
              // Anything but auto-reload behaves as one-shot: drop En on expiry
              if (ctrl_q[g][2:1] != 2'b01) ctrl_q[g][0] <= 1'b0;
            end
          end
          INT: if (ctrl_q[g][2:1] == 2'b01) state_q[g] <= LOAD;
          default: state_q[g] <= IDLE;
        endcase

        if (wr_preset[g]) preset_q[g] <= merge_bytes(preset_q[g], PrWD, PrBE);

        // CTRL write is placed last so it overrides the En clear and any
        // state transition (including expiry) taken above in the same cycle
        if (wr_ctrl[g]) begin
          if (PrBE[0]) ctrl_q[g] <= PrWD[3:0];
          state_q[g] <= IDLE;
        end
      end
    end
  end

  // Read data: hit timer's selected register, zero on miss
  always_comb begin
    PrRD = '0;
    if (hit[0])      PrRD = rd_data[0];
    else if (hit[1]) PrRD = rd_data[1];
  end

  // External interrupt lines registered once
  always_ff @(posedge clk) begin
    if (!reset) ext_q <= '0;
    else        ext_q <= ExtInt;
  end

  assign HWInt = {ext_q, irq};

endmodule

// File: tb/tb_pr_timer_bridge.sv
// Directed self-checking bench for pr_timer_bridge.
module tb_pr_timer_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] PrAddr;
  logic [3:0]  PrBE;
  logic [31:0] PrWD;
  logic        PrWe;
  logic [3:0]  ExtInt;
  logic [31:0] PrRD;
  logic [7:2]  HWInt;

  int checks;
  int failures;

  pr_timer_bridge #(
    .TC0_BASE(32'h0000_7F00),
    .TC1_BASE(32'h0000_7F10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .PrAddr(PrAddr),
    .PrBE  (PrBE),
    .PrWD  (PrWD),
    .PrWe  (PrWe),
    .ExtInt(ExtInt),
    .PrRD  (PrRD),
    .HWInt (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    PrAddr = a;
    PrBE   = be;
    PrWD   = d;
    PrWe   = 1'b1;
    tick();
    PrWe   = 1'b0;
    PrBE   = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    PrAddr = a;
    #1;
    d = PrRD;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [3];
    addrs[0] = 32'h7F00; addrs[1] = 32'h7F04; addrs[2] = 32'h7F08;
    reset = 1'b0; ExtInt = 4'hF;
    tick(); tick();
    checks++;
    if (HWInt !== 6'b0) begin
      failures++; $display("FAIL reset_hwint got=%b want=%b", HWInt, 6'b0);
    end
    for (int i = 0; i < 3; i++) begin
      rd(addrs[i], d);
      checks++;
      if (d !== 32'h0) begin
        failures++; $display("FAIL reset_prrd addr=%h got=%h want=%h", addrs[i], d, 32'h0);
      end
    end
    reset = 1'b1; ExtInt = 4'h0;
    tick();
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    cpu_write(32'h7F04, 4'hF, 32'd3);
    cpu_write(32'h7F00, 4'hF, 32'h9);        // edge 0
    tick();                                   // edge 1 (LOAD)
    for (int k = 2; k <= 5; k++) begin
      tick();
      rd(32'h7F08, d);
      checks++;
      if (d !== 32'(5 - k)) begin
        failures++; $display("FAIL oneshot_count edge=%0d got=%0d want=%0d", k, d, 5 - k);
      end
      checks++;
      if (HWInt[2] !== (k == 5)) begin
        failures++; $display("FAIL oneshot_irq edge=%0d got=%b want=%b", k, HWInt[2], (k == 5));
      end
    end
    tick();
    checks++;
    if (HWInt[2] !== 1'b1) begin
      failures++; $display("FAIL oneshot_irq_hold got=%b want=1", HWInt[2]);
    end
    rd(32'h7F00, d);
    checks++;
    if (d !== 32'h8) begin
      failures++; $display("FAIL oneshot_ctrl_en_clr got=%h want=%h", d, 32'h8);
    end
    cpu_write(32'h7F00, 4'hF, 32'h8);
    checks++;
    if (HWInt[2] !== 1'b0) begin
      failures++; $display("FAIL oneshot_irq_clear got=%b want=0", HWInt[2]);
    end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic [31:0] exp_cnt;
    cpu_write(32'h7F14, 4'hF, 32'd2);
    cpu_write(32'h7F10, 4'hF, 32'hB);        // edge 0
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (HWInt[3] !== ((k % 4) == 0)) begin
        failures++; $display("FAIL autoreload_irq edge=%0d got=%b want=%b", k, HWInt[3], ((k % 4) == 0));
      end
      checks++;
      if (HWInt[2] !== 1'b0) begin
        failures++; $display("FAIL autoreload_tc0_quiet edge=%0d got=%b want=0", k, HWInt[2]);
      end
      if (k >= 2) begin
        case (k % 4)
          2:       exp_cnt = 32'd2;
          3:       exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
        rd(32'h7F18, d);
        checks++;
        if (d !== exp_cnt) begin
          failures++; $display("FAIL autoreload_count edge=%0d got=%0d want=%0d", k, d, exp_cnt);
        end
      end
    end
    cpu_write(32'h7F10, 4'hF, 32'h0);
    // IM=0: counting continues, no interrupt
    cpu_write(32'h7F10, 4'hF, 32'h3);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (HWInt[3] !== 1'b0) begin
        failures++; $display("FAIL masked_irq edge=%0d got=%b want=0", k, HWInt[3]);
      end
      if (k >= 2) begin
        case (k % 4)
          2:       exp_cnt = 32'd2;
          3:       exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
        rd(32'h7F18, d);
        checks++;
        if (d !== exp_cnt) begin
          failures++; $display("FAIL masked_count edge=%0d got=%0d want=%0d", k, d, exp_cnt);
        end
      end
    end
    cpu_write(32'h7F10, 4'hF, 32'h0);
  endtask

  task automatic test_byte_enables();
    logic [31:0] d;
    cpu_write(32'h7F04, 4'hF, 32'h0);
    cpu_write(32'h7F04, 4'b0101, 32'hAABBCCDD);
    rd(32'h7F04, d);
    checks++;
    if (d !== 32'h00BB00DD) begin
      failures++; $display("FAIL be_preset got=%h want=%h", d, 32'h00BB00DD);
    end
    cpu_write(32'h7F04, 4'b1000, 32'h11223344);
    rd(32'h7F04, d);
    checks++;
    if (d !== 32'h11BB00DD) begin
      failures++; $display("FAIL be_preset_hi got=%h want=%h", d, 32'h11BB00DD);
    end
    cpu_write(32'h7F08, 4'hF, 32'hFFFFFFFF);
    rd(32'h7F08, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL count_ro got=%h want=%h", d, 32'h0);
    end
    cpu_write(32'h7F00, 4'hF, 32'hFFFFFFF0);
    rd(32'h7F00, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL ctrl_upper got=%h want=%h", d, 32'h0);
    end
    cpu_write(32'h7F0C, 4'hF, 32'h12345678);
    rd(32'h7F0C, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL reserved_rd got=%h want=%h", d, 32'h0);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    cpu_write(32'h7F04, 4'hF, 32'd3);
    cpu_write(32'h7F00, 4'hF, 32'h9);        // edge 0
    for (int k = 1; k <= 4; k++) tick();
    rd(32'h7F08, d);
    checks++;
    if (d !== 32'd1) begin
      failures++; $display("FAIL collide_pre_count got=%0d want=1", d);
    end
    cpu_write(32'h7F00, 4'hF, 32'h8);        // expiry edge
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (HWInt[2] !== 1'b0) begin
        failures++; $display("FAIL collide_no_irq cyc=%0d got=%b want=0", k, HWInt[2]);
      end
      tick();
    end
    // PRESET 0 expires one CNT cycle after LOAD
    cpu_write(32'h7F04, 4'hF, 32'd0);
    cpu_write(32'h7F00, 4'hF, 32'h9);        // edge 0
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (HWInt[2] !== (k == 3)) begin
        failures++; $display("FAIL preset0_irq edge=%0d got=%b want=%b", k, HWInt[2], (k == 3));
      end
    end
    cpu_write(32'h7F00, 4'hF, 32'h0);
  endtask

  task automatic test_decode();
    logic [31:0] d;
    rd(32'h7F14, d);
    checks++;
    if (d !== 32'd2) begin
      failures++; $display("FAIL decode_tc1_preset got=%h want=%h", d, 32'd2);
    end
    rd(32'h7F0C, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL decode_reserved got=%h want=0", d);
    end
    rd(32'h7F20, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL decode_miss got=%h want=0", d);
    end
    ExtInt = 4'b1010;
    #1;
    checks++;
    if (HWInt[7:4] !== 4'b0000) begin
      failures++; $display("FAIL ext_before_edge got=%b want=0000", HWInt[7:4]);
    end
    tick();
    checks++;
    if (HWInt[7:4] !== 4'b1010) begin
      failures++; $display("FAIL ext_registered got=%b want=1010", HWInt[7:4]);
    end
    ExtInt = 4'b0000;
    tick();
  endtask

  task automatic test_reset_midcount();
    logic [31:0] d;
    cpu_write(32'h7F14, 4'hF, 32'd5);
    cpu_write(32'h7F10, 4'hF, 32'hB);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (HWInt !== 6'b0) begin
      failures++; $display("FAIL midreset_hwint got=%b want=0", HWInt);
    end
    rd(32'h7F18, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL midreset_count got=%h want=0", d);
    end
    rd(32'h7F14, d);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL midreset_preset got=%h want=0", d);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (HWInt[3] !== 1'b0) begin
        failures++; $display("FAIL midreset_no_irq cyc=%0d got=%b want=0", k, HWInt[3]);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b0; PrAddr = '0; PrBE = '0; PrWD = '0; PrWe = 1'b0; ExtInt = '0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_byte_enables();
    test_collision();
    test_decode();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
